// File: rtl/scan_sequencer_pkg.sv
// Shared types and widths for the scan sequencer: FSM state encoding,
// counter widths and the default txdone pulse width.
package scan_pkg;

  localparam int FRAME_W          = 8;
  localparam int SCAN_W           = 16;
  localparam int TXDONE_W_DEFAULT = 4;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_FIRE = 3'd1,
    S_RUN  = 3'd2,
    S_GAP  = 3'd3,
    S_DONE = 3'd4
  } state_t;

endpackage

// File: rtl/scan_sequencer_edge_sync.sv
// edge_sync: 2-flop synchronizer for an asynchronous level, plus a registered
// rising-edge pulse (visible 3 clocks after the input transition).
module edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic sync,
  output logic rise
);

  logic meta_reg;
  logic sync_reg;
  logic prev_reg;
  logic rise_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_reg <= 1'b0;
      sync_reg <= 1'b0;
      prev_reg <= 1'b0;
      rise_reg <= 1'b0;
    end else begin
      meta_reg <= din;
      sync_reg <= meta_reg;
      prev_reg <= sync_reg;
      rise_reg <= sync_reg & ~prev_reg;
    end
  end

  assign sync = sync_reg;
  assign rise = rise_reg;

endmodule

// File: rtl/scan_sequencer.sv
// Scan sequencer: fires the signal generator, counts frames per scan and scans
// per run. Define SCAN_SEQ_TIMEOUT_EN to build the frame-edge watchdog.
module scan_sequencer
  import scan_pkg::*;
#(
  parameter int          TXDONE_W       = TXDONE_W_DEFAULT,
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd4_000_000
) (
  input  logic                 clk_400m,
  input  logic                 reset,
  input  logic                 cfg_valid,
  output logic                 cfg_ready,
  input  logic [FRAME_W-1:0]   cfg_frame_nums,
  input  logic [FRAME_W-1:0]   cfg_pixel_nums,
  input  logic [SCAN_W-1:0]    cfg_repeat,
  input  logic [SCAN_W-1:0]    cfg_gap,
  input  logic                 cmd_start,
  input  logic                 cmd_abort,
  input  logic                 frame,
  input  logic                 pixel,
  output logic                 txdone,
  output logic [FRAME_W-1:0]   frame_nums,
  output logic [FRAME_W-1:0]   pixel_nums,
  output logic                 busy,
  output logic                 scan_done,
  output logic                 aborted,
  output logic [SCAN_W-1:0]    scan_cnt,
  output logic [FRAME_W-1:0]   frame_cnt,
  output logic                 err_cfg,
  output logic                 err_timeout
);

  localparam int                FIRE_W    = (TXDONE_W > 1) ? $clog2(TXDONE_W) : 1;
  localparam logic [FIRE_W-1:0] FIRE_LAST = FIRE_W'(TXDONE_W - 1);

  state_t              state;
  logic                txdone_reg;
  logic                scan_done_reg;
  logic                aborted_reg;
  logic                err_cfg_reg;
  logic [FRAME_W-1:0]  frame_nums_reg;
  logic [FRAME_W-1:0]  pixel_nums_reg;
  logic [SCAN_W-1:0]   repeat_reg;
  logic [SCAN_W-1:0]   gap_reg;
  logic [SCAN_W-1:0]   gap_cnt_reg;
  logic [SCAN_W-1:0]   gap_last;
  logic [SCAN_W-1:0]   scan_cnt_reg;
  logic [FRAME_W-1:0]  frame_cnt_reg;
  logic [FIRE_W-1:0]   fire_cnt_reg;

  // Index 0 = frame, index 1 = pixel.
  logic [1:0] raw_in;
  logic [1:0] sync_lvl;
  logic [1:0] sync_rise;
  logic       frame_sync;
  logic       frame_rise;
  logic       pixel_rise;
  logic       unused_pixel_sync;

  assign raw_in = {pixel, frame};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_sync
      edge_sync u_edge_sync (
        .clk   (clk_400m),
        .rst_n (reset),
        .din   (raw_in[gi]),
        .sync  (sync_lvl[gi]),
        .rise  (sync_rise[gi])
      );
    end
  endgenerate

  assign frame_sync        = sync_lvl[0];
  assign frame_rise        = sync_rise[0];
  assign pixel_rise        = sync_rise[1];
  assign unused_pixel_sync = sync_lvl[1];

  // A zero gap still costs one idle cycle.
  assign gap_last = (gap_reg == '0) ? '0 : gap_reg - 1'b1;

`ifdef SCAN_SEQ_TIMEOUT_EN
  localparam logic [31:0] WD_LAST = TIMEOUT_CYCLES - 32'd1;
  logic [31:0] wd_cnt_reg;
  logic        err_timeout_reg;
  assign err_timeout = err_timeout_reg;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign err_timeout    = 1'b0;
`endif

  always_ff @(posedge clk_400m or negedge reset) begin
    if (!reset) begin
      state          <= S_IDLE;
      txdone_reg     <= 1'b0;
      scan_done_reg  <= 1'b0;
      aborted_reg    <= 1'b0;
      err_cfg_reg    <= 1'b0;
      frame_nums_reg <= '0;
      pixel_nums_reg <= '0;
      repeat_reg     <= '0;
      gap_reg        <= '0;
      gap_cnt_reg    <= '0;
      scan_cnt_reg   <= '0;
      frame_cnt_reg  <= '0;
      fire_cnt_reg   <= '0;
`ifdef SCAN_SEQ_TIMEOUT_EN
      wd_cnt_reg      <= '0;
      err_timeout_reg <= 1'b0;
`endif
    end else begin
      scan_done_reg <= 1'b0;
      aborted_reg   <= 1'b0;
      case (state)
        S_IDLE: begin
          if (cfg_valid) begin
            frame_nums_reg <= cfg_frame_nums;
            pixel_nums_reg <= cfg_pixel_nums;
            repeat_reg     <= cfg_repeat;
            gap_reg        <= cfg_gap;
            err_cfg_reg    <= 1'b0;
`ifdef SCAN_SEQ_TIMEOUT_EN
            err_timeout_reg <= 1'b0;
`endif
          end
          if (cmd_start && !cmd_abort) begin
            if (frame_nums_reg != '0) begin
              state         <= S_FIRE;
              txdone_reg    <= 1'b1;
              fire_cnt_reg  <= '0;
              frame_cnt_reg <= '0;
              scan_cnt_reg  <= '0;
            end else begin
              err_cfg_reg <= 1'b1;
            end
          end
        end
        S_FIRE: begin
          if (fire_cnt_reg == FIRE_LAST) begin
            state      <= S_RUN;
            txdone_reg <= 1'b0;
`ifdef SCAN_SEQ_TIMEOUT_EN
            wd_cnt_reg <= '0;
`endif
          end else begin
            fire_cnt_reg <= fire_cnt_reg + 1'b1;
          end
        end
        S_RUN: begin
          if (frame_rise && frame_cnt_reg != '1)
            frame_cnt_reg <= frame_cnt_reg + 1'b1;
          if (pixel_rise && !frame_sync)
            err_cfg_reg <= 1'b1;
          // Scan ends once the last frame has also gone low again.
          if (frame_cnt_reg >= frame_nums_reg && !frame_sync) begin
            state       <= S_GAP;
            gap_cnt_reg <= '0;
            if (scan_cnt_reg != '1)
              scan_cnt_reg <= scan_cnt_reg + 1'b1;
          end
`ifdef SCAN_SEQ_TIMEOUT_EN
          else if (frame_rise) begin
            wd_cnt_reg <= '0;
          end else if (wd_cnt_reg == WD_LAST) begin
            err_timeout_reg <= 1'b1;
            aborted_reg     <= 1'b1;
            state           <= S_IDLE;
          end else begin
            wd_cnt_reg <= wd_cnt_reg + 32'd1;
          end
`endif
        end
        S_GAP: begin
          if (gap_cnt_reg >= gap_last) begin
            if (repeat_reg != '0 && scan_cnt_reg == repeat_reg) begin
              state         <= S_DONE;
              scan_done_reg <= 1'b1;
            end else begin
              state         <= S_FIRE;
              txdone_reg    <= 1'b1;
              fire_cnt_reg  <= '0;
              frame_cnt_reg <= '0;
            end
          end else begin
            gap_cnt_reg <= gap_cnt_reg + 1'b1;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
      // Abort overrides whatever the active state decided this cycle.
      if (cmd_abort && state != S_IDLE) begin
        state         <= S_IDLE;
        txdone_reg    <= 1'b0;
        aborted_reg   <= 1'b1;
        scan_done_reg <= 1'b0;
      end
    end
  end

  assign cfg_ready  = (state == S_IDLE);
  assign busy       = (state != S_IDLE);
  assign txdone     = txdone_reg;
  assign scan_done  = scan_done_reg;
  assign aborted    = aborted_reg;
  assign frame_nums = frame_nums_reg;
  assign pixel_nums = pixel_nums_reg;
  assign scan_cnt   = scan_cnt_reg;
  assign frame_cnt  = frame_cnt_reg;
  assign err_cfg    = err_cfg_reg;

endmodule

// File: tb/tb_scan_sequencer.sv
// Directed self-checking bench for scan_sequencer; the watchdog scenario is
// selected by SCAN_SEQ_TIMEOUT_EN to match the RTL build.
`timescale 1ns/1ps
module tb_scan_sequencer;

  logic        clk_400m = 1'b0;
  logic        reset = 1'b0;
  logic        cfg_valid = 1'b0;
  logic        cfg_ready;
  logic [7:0]  cfg_frame_nums = '0;
  logic [7:0]  cfg_pixel_nums = '0;
  logic [15:0] cfg_repeat = '0;
  logic [15:0] cfg_gap = '0;
  logic        cmd_start = 1'b0;
  logic        cmd_abort = 1'b0;
  logic        frame = 1'b0;
  logic        pixel = 1'b0;
  logic        txdone;
  logic [7:0]  frame_nums;
  logic [7:0]  pixel_nums;
  logic        busy;
  logic        scan_done;
  logic        aborted;
  logic [15:0] scan_cnt;
  logic [7:0]  frame_cnt;
  logic        err_cfg;
  logic        err_timeout;

  int tests = 0;
  int fails = 0;
  int done_seen = 0;
  int abort_seen = 0;

  scan_sequencer #(
    .TXDONE_W       (4),
    .TIMEOUT_CYCLES (32'd100)
  ) dut (
    .clk_400m       (clk_400m),
    .reset          (reset),
    .cfg_valid      (cfg_valid),
    .cfg_ready      (cfg_ready),
    .cfg_frame_nums (cfg_frame_nums),
    .cfg_pixel_nums (cfg_pixel_nums),
    .cfg_repeat     (cfg_repeat),
    .cfg_gap        (cfg_gap),
    .cmd_start      (cmd_start),
    .cmd_abort      (cmd_abort),
    .frame          (frame),
    .pixel          (pixel),
    .txdone         (txdone),
    .frame_nums     (frame_nums),
    .pixel_nums     (pixel_nums),
    .busy           (busy),
    .scan_done      (scan_done),
    .aborted        (aborted),
    .scan_cnt       (scan_cnt),
    .frame_cnt      (frame_cnt),
    .err_cfg        (err_cfg),
    .err_timeout    (err_timeout)
  );

  always #5 clk_400m = ~clk_400m;

  always @(negedge clk_400m) begin
    if (scan_done) done_seen++;
    if (aborted)   abort_seen++;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish, tests=%0d", tests);
    $fatal(1, "timeout");
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk_400m);
  endtask

  task automatic send_cfg(input logic [7:0] f, input logic [7:0] p,
                          input logic [15:0] r, input logic [15:0] g);
    cfg_frame_nums = f;
    cfg_pixel_nums = p;
    cfg_repeat     = r;
    cfg_gap        = g;
    cfg_valid      = 1'b1;
    @(negedge clk_400m);
    cfg_valid      = 1'b0;
  endtask

  task automatic pulse_start();
    cmd_start = 1'b1;
    @(negedge clk_400m);
    cmd_start = 1'b0;
  endtask

  task automatic pulse_abort();
    cmd_abort = 1'b1;
    @(negedge clk_400m);
    cmd_abort = 1'b0;
  endtask

  // Frame high 6 cycles with one pixel inside it, then low 6 cycles.
  task automatic frame_pulse();
    frame = 1'b1;
    @(negedge clk_400m);
    pixel = 1'b1;
    @(negedge clk_400m);
    pixel = 1'b0;
    cyc(4);
    frame = 1'b0;
    cyc(6);
  endtask

  // Returns the txdone high width (0 if it never rose); ends on the first low sample.
  task automatic wait_txdone(output int width);
    int n;
    n = 0;
    width = 0;
    while (!txdone && n < 200) begin
      @(negedge clk_400m);
      n++;
    end
    while (txdone && width < 50) begin
      @(negedge clk_400m);
      width++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    cyc(3);
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %0b expected 0", busy); end
    tests++; if (cfg_ready !== 1'b1) begin fails++; $display("FAIL reset_cfg_ready: got %0b expected 1", cfg_ready); end
    tests++; if (txdone !== 1'b0) begin fails++; $display("FAIL reset_txdone: got %0b expected 0", txdone); end
    tests++; if (scan_cnt !== 16'd0 || frame_cnt !== 8'd0) begin fails++; $display("FAIL reset_counts: got scan=%0d frame=%0d expected 0/0", scan_cnt, frame_cnt); end
    tests++; if (frame_nums !== 8'd0 || err_cfg !== 1'b0 || err_timeout !== 1'b0) begin fails++; $display("FAIL reset_regs: got fn=%0d ec=%0b et=%0b expected 0", frame_nums, err_cfg, err_timeout); end
    reset = 1'b1;
    cyc(2);
    tests++; if (cfg_ready !== 1'b1) begin fails++; $display("FAIL reset_release_ready: got %0b expected 1", cfg_ready); end
    $display("[TB] test_reset done");
  endtask

  task automatic test_cfg_zero();
    bit saw;
    send_cfg(8'd0, 8'd4, 16'd1, 16'd2);
    pulse_start();
    saw = 1'b0;
    repeat (6) begin
      if (txdone || busy) saw = 1'b1;
      @(negedge clk_400m);
    end
    tests++; if (err_cfg !== 1'b1) begin fails++; $display("FAIL cfg_zero_err: got %0b expected 1", err_cfg); end
    tests++; if (saw !== 1'b0) begin fails++; $display("FAIL cfg_zero_activity: got busy/txdone seen=%0b expected 0", saw); end
    $display("[TB] test_cfg_zero done");
  endtask

  task automatic test_two_scans();
    int w, n, d0;
    send_cfg(8'd3, 8'd5, 16'd2, 16'd10);
    tests++; if (err_cfg !== 1'b0) begin fails++; $display("FAIL two_err_cleared: got %0b expected 0", err_cfg); end
    tests++; if (frame_nums !== 8'd3 || pixel_nums !== 8'd5) begin fails++; $display("FAIL two_latch: got %0d/%0d expected 3/5", frame_nums, pixel_nums); end
    d0 = done_seen;
    pulse_start();
    wait_txdone(w);
    tests++; if (w !== 4) begin fails++; $display("FAIL two_txdone1_width: got %0d expected 4", w); end
    repeat (3) frame_pulse();
    cyc(2);
    tests++; if (scan_cnt !== 16'd1 || frame_cnt !== 8'd3) begin fails++; $display("FAIL two_scan1: got scan=%0d frame=%0d expected 1/3", scan_cnt, frame_cnt); end
    wait_txdone(w);
    tests++; if (w !== 4) begin fails++; $display("FAIL two_txdone2_width: got %0d expected 4", w); end
    tests++; if (frame_cnt !== 8'd0) begin fails++; $display("FAIL two_frame_clear: got %0d expected 0", frame_cnt); end
    repeat (3) frame_pulse();
    n = 0;
    while (!scan_done && n < 100) begin
      @(negedge clk_400m);
      n++;
    end
    tests++; if (scan_done !== 1'b1 || scan_cnt !== 16'd2) begin fails++; $display("FAIL two_done: got done=%0b scan=%0d expected 1/2", scan_done, scan_cnt); end
    @(negedge clk_400m);
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL two_busy_after_done: got %0b expected 0", busy); end
    cyc(2);
    tests++; if (done_seen - d0 !== 1) begin fails++; $display("FAIL two_done_count: got %0d expected 1", done_seen - d0); end
    tests++; if (err_cfg !== 1'b0) begin fails++; $display("FAIL two_no_pixel_err: got %0b expected 0", err_cfg); end
    $display("[TB] test_two_scans done");
  endtask

  task automatic test_continuous_abort();
    int w, n, d0, a0;
    send_cfg(8'd1, 8'd1, 16'd0, 16'd30);
    d0 = done_seen;
    a0 = abort_seen;
    pulse_start();
    for (int i = 1; i <= 5; i++) begin
      wait_txdone(w);
      frame_pulse();
      n = 0;
      while (scan_cnt != 16'(i) && n < 100) begin
        @(negedge clk_400m);
        n++;
      end
    end
    tests++; if (scan_cnt !== 16'd5 || busy !== 1'b1) begin fails++; $display("FAIL cont_five: got scan=%0d busy=%0b expected 5/1", scan_cnt, busy); end
    pulse_abort();
    tests++; if (aborted !== 1'b1 || busy !== 1'b0 || txdone !== 1'b0) begin fails++; $display("FAIL cont_abort: got ab=%0b busy=%0b tx=%0b expected 1/0/0", aborted, busy, txdone); end
    tests++; if (scan_cnt !== 16'd5) begin fails++; $display("FAIL cont_scan_kept: got %0d expected 5", scan_cnt); end
    cyc(2);
    tests++; if (abort_seen - a0 !== 1 || done_seen - d0 !== 0) begin fails++; $display("FAIL cont_pulses: got aborts=%0d dones=%0d expected 1/0", abort_seen - a0, done_seen - d0); end
    $display("[TB] test_continuous_abort done");
  endtask

  task automatic test_start_abort_same();
    bit saw;
    int a0;
    send_cfg(8'd2, 8'd4, 16'd1, 16'd3);
    tests++; if (frame_nums !== 8'd2) begin fails++; $display("FAIL same_latch: got %0d expected 2", frame_nums); end
    a0 = abort_seen;
    cmd_start = 1'b1;
    cmd_abort = 1'b1;
    @(negedge clk_400m);
    cmd_start = 1'b0;
    cmd_abort = 1'b0;
    saw = 1'b0;
    repeat (8) begin
      if (txdone || busy) saw = 1'b1;
      @(negedge clk_400m);
    end
    tests++; if (saw !== 1'b0) begin fails++; $display("FAIL same_no_fire: got activity=%0b expected 0", saw); end
    tests++; if (abort_seen - a0 !== 0) begin fails++; $display("FAIL same_no_abort_pulse: got %0d expected 0", abort_seen - a0); end
    $display("[TB] test_start_abort_same done");
  endtask

  task automatic test_cfg_in_run();
    int w;
    pulse_start();
    wait_txdone(w);
    tests++; if (cfg_ready !== 1'b0) begin fails++; $display("FAIL run_cfg_ready: got %0b expected 0", cfg_ready); end
    send_cfg(8'd9, 8'd9, 16'd7, 16'd7);
    tests++; if (frame_nums !== 8'd2 || pixel_nums !== 8'd4) begin fails++; $display("FAIL run_cfg_ignored: got %0d/%0d expected 2/4", frame_nums, pixel_nums); end
    pixel = 1'b1;
    cyc(2);
    pixel = 1'b0;
    cyc(4);
    tests++; if (err_cfg !== 1'b1 || busy !== 1'b1) begin fails++; $display("FAIL run_pixel_err: got err=%0b busy=%0b expected 1/1", err_cfg, busy); end
    pulse_abort();
    tests++; if (aborted !== 1'b1) begin fails++; $display("FAIL run_abort: got %0b expected 1", aborted); end
    cyc(2);
    $display("[TB] test_cfg_in_run done");
  endtask

  task automatic test_reset_mid_run();
    int w, a0, d0;
    send_cfg(8'd2, 8'd4, 16'd1, 16'd3);
    pulse_start();
    wait_txdone(w);
    frame_pulse();
    tests++; if (frame_cnt !== 8'd1 || busy !== 1'b1) begin fails++; $display("FAIL rst_pre: got frame=%0d busy=%0b expected 1/1", frame_cnt, busy); end
    a0 = abort_seen;
    d0 = done_seen;
    reset = 1'b0;
    #1;
    tests++; if (busy !== 1'b0 || txdone !== 1'b0 || frame_cnt !== 8'd0) begin fails++; $display("FAIL rst_async: got busy=%0b tx=%0b frame=%0d expected 0/0/0", busy, txdone, frame_cnt); end
    tests++; if (frame_nums !== 8'd0 || cfg_ready !== 1'b1) begin fails++; $display("FAIL rst_async_regs: got fn=%0d ready=%0b expected 0/1", frame_nums, cfg_ready); end
    cyc(3);
    reset = 1'b1;
    cyc(3);
    tests++; if (cfg_ready !== 1'b1 || busy !== 1'b0) begin fails++; $display("FAIL rst_release: got ready=%0b busy=%0b expected 1/0", cfg_ready, busy); end
    tests++; if (abort_seen - a0 !== 0 || done_seen - d0 !== 0) begin fails++; $display("FAIL rst_no_pulses: got aborts=%0d dones=%0d expected 0/0", abort_seen - a0, done_seen - d0); end
    $display("[TB] test_reset_mid_run done");
  endtask

`ifdef SCAN_SEQ_TIMEOUT_EN
  task automatic test_timeout();
    int w, n, a0;
    send_cfg(8'd2, 8'd4, 16'd1, 16'd3);
    a0 = abort_seen;
    pulse_start();
    wait_txdone(w);
    n = 0;
    while (busy && n < 300) begin
      @(negedge clk_400m);
      n++;
    end
    tests++; if (n !== 100) begin fails++; $display("FAIL timeout_cycles: got %0d expected 100", n); end
    tests++; if (err_timeout !== 1'b1) begin fails++; $display("FAIL timeout_flag: got %0b expected 1", err_timeout); end
    cyc(1);
    tests++; if (abort_seen - a0 !== 1) begin fails++; $display("FAIL timeout_abort_pulse: got %0d expected 1", abort_seen - a0); end
    send_cfg(8'd2, 8'd4, 16'd1, 16'd3);
    tests++; if (err_timeout !== 1'b0) begin fails++; $display("FAIL timeout_clear: got %0b expected 0", err_timeout); end
    $display("[TB] test_timeout done");
  endtask
`else
  task automatic test_timeout();
    int w;
    send_cfg(8'd2, 8'd4, 16'd1, 16'd3);
    pulse_start();
    wait_txdone(w);
    cyc(150);
    tests++; if (busy !== 1'b1 || err_timeout !== 1'b0) begin fails++; $display("FAIL no_watchdog: got busy=%0b et=%0b expected 1/0", busy, err_timeout); end
    pulse_abort();
    cyc(2);
    $display("[TB] test_timeout done");
  endtask
`endif

  initial begin
    test_reset();
    test_cfg_zero();
    test_two_scans();
    test_continuous_abort();
    test_start_abort_same();
    test_cfg_in_run();
    test_timeout();
    test_reset_mid_run();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/scan_sequencer.md
SCAN_SEQUENCER -- requirements
Module: scan_sequencer

Interface
REQ-001 Parameter: TXDONE_W, default 4, width in clocks of the txdone start pulse to the signal generator.
REQ-002 Parameter: TIMEOUT_CYCLES, default 32'd4_000_000, frame-edge watchdog limit.
REQ-003 clk_400m  input  1  sole clock; every flop is on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 cfg_valid / cfg_ready  input / output  1 / 1  config handshake; the transfer happens on a cycle where both are high.
REQ-006 cfg_frame_nums, cfg_pixel_nums  input  8 each  frames per scan and pixels per frame.
REQ-007 cfg_repeat  input  16  scans per run; 0 means run continuously until abort.
REQ-008 cfg_gap  input  16  idle clocks between scans.
REQ-009 cmd_start, cmd_abort  input  1 each  single-cycle command pulses.
REQ-010 frame, pixel  input  1 each  generator outputs being monitored; treated as asynchronous.
REQ-011 txdone  output  1  start pulse to the signal generator.
REQ-012 frame_nums, pixel_nums  output  8 each  latched config driven to the generator.
REQ-013 busy, scan_done, aborted  output  1 each
- busy: level.
- scan_done: 1-cycle pulse at end of run.
- aborted: 1-cycle pulse.
REQ-014 scan_cnt  output  16  completed scans in the current run.
REQ-015 frame_cnt  output  8  frame edges seen in the current scan.
REQ-016 err_cfg, err_timeout  output  1 each  sticky error flags.

Function
REQ-017 States:
- IDLE, FIRE, RUN, GAP, DONE.
- Encoding comes from the package.
REQ-018 cfg_ready is high only in IDLE; an accepted config is latched into frame_nums, pixel_nums, the repeat register and the gap register.
REQ-019 IDLE->FIRE on cmd_start when the latched frame_nums is nonzero.
- cmd_start with frame_nums==0 sets err_cfg and stays in IDLE.
REQ-020 FIRE:
- txdone is high for exactly TXDONE_W cycles, then the FSM goes to RUN.
- frame_cnt is cleared on FIRE entry.
REQ-021 frame and pixel each pass a 2-flop synchronizer plus rising-edge detect; an edge is visible 3 cycles after the input transition.
REQ-022 RUN:
- Each frame edge increments frame_cnt.
- When frame_cnt reaches frame_nums and the synchronized frame is low, go to GAP and increment scan_cnt.
REQ-023 GAP counts cfg_gap cycles (0 means 1 cycle), then:
- goes to DONE when scan_cnt==repeat and repeat!=0;
- otherwise goes to FIRE.
REQ-024 DONE pulses scan_done for 1 cycle, then goes to IDLE.
REQ-025 scan_cnt and frame_cnt stop incrementing at their 16-bit and 8-bit maxima; they never wrap.
REQ-026 Frame edges outside RUN are ignored.
REQ-027 Pixel edges are only checked in RUN; a pixel edge while the synchronized frame is low sets err_cfg.
REQ-028 cmd_abort in any non-IDLE state:
- next state is IDLE;
- txdone goes low on the next cycle;
- aborted pulses 1 cycle;
- no scan_done is issued.
REQ-029 cmd_start and cmd_abort in the same IDLE cycle: abort wins and no state change occurs.
REQ-030 cmd_start outside IDLE is ignored.
REQ-031 busy = (state != IDLE).
REQ-032 Error flags clear only on reset or on the next accepted cfg handshake.

Reset
REQ-033 While reset is low:
- state = IDLE;
- every output and counter = 0;
- cfg_ready = 1;
- synchronizer flops = 0.
REQ-034 A reset asserted mid-scan drops txdone asynchronously; no done or aborted pulse is produced.

Configuration
REQ-035 SCAN_SEQ_TIMEOUT_EN defined: in RUN, if TIMEOUT_CYCLES clocks pass without a frame edge, err_timeout is set and the FSM goes to IDLE with an aborted pulse.
REQ-036 SCAN_SEQ_TIMEOUT_EN undefined: no watchdog counter is built and err_timeout is tied to 0.

Structure
REQ-037 Package scan_pkg holds:
- the state enum;
- the count widths (8/16);
- the default TXDONE_W.
REQ-038 One sub-module, edge_sync (2-flop synchronizer plus rising-edge pulse), is instantiated for frame and for pixel.

Verification
REQ-039 Config frame=3, gap=10, repeat=2, then cmd_start -> two 4-cycle txdone pulses; scan_cnt goes 1 then 2; one scan_done; busy drops after DONE.
REQ-040 repeat=0, run 5 scans, then cmd_abort in GAP -> aborted pulse, scan_cnt=5, no scan_done, IDLE next cycle.
REQ-041 cfg_frame_nums=0, then cmd_start -> err_cfg=1, busy stays 0, txdone stays 0.
REQ-042 Start and abort in the same cycle in IDLE -> no txdone; cfg_valid during RUN -> not accepted, latched values unchanged.
REQ-043 With SCAN_SEQ_TIMEOUT_EN and TIMEOUT_CYCLES=100, hold frame low after FIRE -> err_timeout=1 at cycle 100 of RUN, state returns to IDLE.
REQ-044 Reset pulsed low during RUN -> all outputs 0 immediately; cfg_ready=1 after release.
